// File: rtl/rtc_banco_lectura.sv
// RTC read bank: drives the address byte chosen by the read sequencer, captures the
// bytes it returns into shadow registers, and commits a validated snapshot on ready.
module rtc_banco_lectura #(
    parameter logic [7:0] ADDR_COM   = 8'hF0,
    parameter logic [7:0] ADDR_SEG   = 8'h21,
    parameter logic [7:0] ADDR_MIN   = 8'h22,
    parameter logic [7:0] ADDR_HORA  = 8'h23,
    parameter logic [7:0] ADDR_DIA   = 8'h24,
    parameter logic [7:0] ADDR_MES   = 8'h25,
    parameter logic [7:0] ADDR_ANIO  = 8'h26,
    parameter logic [7:0] ADDR_TSEG  = 8'h41,
    parameter logic [7:0] ADDR_TMIN  = 8'h42,
    parameter logic [7:0] ADDR_THORA = 8'h43
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dato_in,
    input  logic       seg_in,
    input  logic       min_in,
    input  logic       hora_in,
    input  logic       dia_in,
    input  logic       mes_in,
    input  logic       anio_in,
    input  logic       tseg_in,
    input  logic       tmin_in,
    input  logic       thora_in,
    input  logic       dir_com_cyt,
    input  logic       dir_seg,
    input  logic       dir_min,
    input  logic       dir_hora,
    input  logic       dir_dia,
    input  logic       dir_mes,
    input  logic       dir_anio,
    input  logic       dir_tseg,
    input  logic       dir_tmin,
    input  logic       dir_thora,
    input  logic       buffer_activo,
    input  logic       ready,
    output logic [7:0] dato_out,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] tseg,
    output logic [7:0] tmin,
    output logic [7:0] thora,
    output logic       snap_valid,
    output logic       snap_stb,
    output logic       bcd_err,
    output logic [7:0] err_cnt
);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t          state, next_state;
    logic [8:0]      strb;
    logic [8:0]      mask;
    logic [8:0]      mask_pre;
    logic [8:0][7:0] shadow;
    logic [8:0][7:0] snap;
    logic            ready_q;
    logic            rise;
    logic            take_snap;
    logic            accept;
    logic            reject;
    logic            all_bcd;

    // Field index order: seg, min, hora, dia, mes, anio, tseg, tmin, thora
    assign strb = {thora_in, tmin_in, tseg_in, anio_in, mes_in, dia_in, hora_in, min_in, seg_in};
    assign rise = ready & ~ready_q;

    assign seg   = snap[0];
    assign min   = snap[1];
    assign hora  = snap[2];
    assign dia   = snap[3];
    assign mes   = snap[4];
    assign anio  = snap[5];
    assign tseg  = snap[6];
    assign tmin  = snap[7];
    assign thora = snap[8];

    always_comb begin
        dato_out = 8'h00;
        if (buffer_activo) begin
            if      (dir_com_cyt) dato_out = ADDR_COM;
            else if (dir_thora)   dato_out = ADDR_THORA;
            else if (dir_tmin)    dato_out = ADDR_TMIN;
            else if (dir_tseg)    dato_out = ADDR_TSEG;
            else if (dir_anio)    dato_out = ADDR_ANIO;
            else if (dir_mes)     dato_out = ADDR_MES;
            else if (dir_dia)     dato_out = ADDR_DIA;
            else if (dir_hora)    dato_out = ADDR_HORA;
            else if (dir_min)     dato_out = ADDR_MIN;
            else if (dir_seg)     dato_out = ADDR_SEG;
        end
    end

    always_comb begin
        all_bcd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (shadow[i][7:4] > 4'h9 || shadow[i][3:0] > 4'h9) all_bcd = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        take_snap  = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    next_state = CHECK;
                    take_snap  = 1'b1;
                end
            end
            CHECK: begin
                next_state = IDLE;
                if (mask_pre == 9'h1FF && all_bcd) accept = 1'b1;
                else                               reject = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobes on the rise edge land in the fresh mask, so they count toward the next burst
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q    <= 1'b0;
            mask       <= '0;
            mask_pre   <= '0;
            shadow     <= '0;
            snap       <= '0;
            snap_valid <= 1'b0;
            snap_stb   <= 1'b0;
            bcd_err    <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            ready_q  <= ready;
            snap_stb <= accept;
            bcd_err  <= reject;
            for (int i = 0; i < 9; i++) begin
                if (strb[i]) shadow[i] <= dato_in;
            end
            if (take_snap) begin
                mask_pre <= mask;
                mask     <= strb;
            end else begin
                mask     <= mask | strb;
            end
            if (accept) begin
                snap       <= shadow;
                snap_valid <= 1'b1;
            end
            if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
        end
    end

endmodule

// File: tb/tb_rtc_banco_lectura.sv
// Randomized self-checking bench for rtc_banco_lectura with a burst-level reference model.
module tb_rtc_banco_lectura;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dato_in;
    logic [8:0] strb;
    logic [9:0] dir;
    logic       buffer_activo;
    logic       ready;
    logic [7:0] dato_out;
    logic [7:0] seg, min, hora, dia, mes, anio, tseg, tmin, thora;
    logic       snap_valid, snap_stb, bcd_err;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_shadow [9];
    logic [7:0] m_snap   [9];
    bit         m_cap    [9];
    bit         m_valid;
    logic [7:0] m_err;

    always #5 clk = ~clk;

    rtc_banco_lectura dut (
        .clk(clk), .reset(reset), .dato_in(dato_in),
        .seg_in(strb[0]), .min_in(strb[1]), .hora_in(strb[2]), .dia_in(strb[3]),
        .mes_in(strb[4]), .anio_in(strb[5]), .tseg_in(strb[6]), .tmin_in(strb[7]),
        .thora_in(strb[8]),
        .dir_com_cyt(dir[0]), .dir_seg(dir[1]), .dir_min(dir[2]), .dir_hora(dir[3]),
        .dir_dia(dir[4]), .dir_mes(dir[5]), .dir_anio(dir[6]), .dir_tseg(dir[7]),
        .dir_tmin(dir[8]), .dir_thora(dir[9]),
        .buffer_activo(buffer_activo), .ready(ready), .dato_out(dato_out),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .tseg(tseg), .tmin(tmin), .thora(thora),
        .snap_valid(snap_valid), .snap_stb(snap_stb), .bcd_err(bcd_err), .err_cnt(err_cnt)
    );

    function automatic logic [7:0] getOut(input int i);
        case (i)
            0: return seg;
            1: return min;
            2: return hora;
            3: return dia;
            4: return mes;
            5: return anio;
            6: return tseg;
            7: return tmin;
            default: return thora;
        endcase
    endfunction

    function automatic logic [7:0] addrOf(input int i);
        case (i)
            0: return 8'hF0;
            1: return 8'h21;
            2: return 8'h22;
            3: return 8'h23;
            4: return 8'h24;
            5: return 8'h25;
            6: return 8'h26;
            7: return 8'h41;
            8: return 8'h42;
            default: return 8'h43;
        endcase
    endfunction

    // Command strobe wins, then the timer/date/time fields from thora down to seg
    function automatic logic [7:0] addrModel(input logic ba, input logic [9:0] d);
        if (!ba) return 8'h00;
        if (d[0]) return addrOf(0);
        for (int i = 9; i >= 1; i--) if (d[i]) return addrOf(i);
        return 8'h00;
    endfunction

    function automatic bit isBcd(input logic [7:0] b);
        return (b / 16) <= 9 && (b % 16) <= 9;
    endfunction

    function automatic logic [7:0] randBcd();
        int t, u;
        t = $urandom_range(0, 9);
        u = $urandom_range(0, 9);
        return 8'(t * 16 + u);
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic checkSnapshot(input string tag);
        for (int i = 0; i < 9; i++) checkOutput($sformatf("%s_out%0d", tag, i), getOut(i), m_snap[i]);
        checkOutput({tag, "_valid"}, {7'b0, snap_valid}, {7'b0, m_valid});
        checkOutput({tag, "_errcnt"}, err_cnt, m_err);
    endtask

    task automatic modelClear();
        for (int i = 0; i < 9; i++) begin
            m_shadow[i] = 8'h00;
            m_snap[i]   = 8'h00;
            m_cap[i]    = 1'b0;
        end
        m_valid = 1'b0;
        m_err   = 8'h00;
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] b);
        strb      = '0;
        strb[idx] = 1'b1;
        dato_in   = b;
        @(posedge clk); #1;
        strb = '0;
        m_shadow[idx] = b;
        m_cap[idx]    = 1'b1;
    endtask

    task automatic fullBurst(input logic [7:0] b [9]);
        for (int i = 0; i < 9; i++) applyStimulus(i, b[i]);
    endtask

    // Raise ready (optionally with one strobe on the rise edge), hold it, then drop it
    task automatic runReady(input string tag, input int hold, input int rise_idx, input logic [7:0] rise_byte);
        bit acc;
        ready = 1'b1;
        if (rise_idx >= 0) begin
            strb[rise_idx] = 1'b1;
            dato_in        = rise_byte;
        end
        @(posedge clk); #1;
        strb = '0;
        if (rise_idx >= 0) m_shadow[rise_idx] = rise_byte;
        acc = 1'b1;
        for (int i = 0; i < 9; i++) if (!m_cap[i] || !isBcd(m_shadow[i])) acc = 1'b0;
        for (int i = 0; i < 9; i++) m_cap[i] = 1'b0;
        if (rise_idx >= 0) m_cap[rise_idx] = 1'b1;
        checkOutput({tag, "_early"}, {6'b0, snap_stb, bcd_err}, 8'h00);
        @(posedge clk); #1;
        if (acc) begin
            for (int i = 0; i < 9; i++) m_snap[i] = m_shadow[i];
            m_valid = 1'b1;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'h01;
        end
        checkOutput({tag, "_stb"}, {7'b0, snap_stb}, {7'b0, acc});
        checkOutput({tag, "_err"}, {7'b0, bcd_err}, {7'b0, !acc});
        checkSnapshot(tag);
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            if (c == 0 || c == hold - 1)
                checkOutput({tag, "_hold"}, {6'b0, snap_stb, bcd_err}, 8'h00);
        end
        ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic doReset(input string tag);
        #2 reset = 1'b0;
        #1;
        modelClear();
        checkSnapshot(tag);
        checkOutput({tag, "_pulses"}, {6'b0, snap_stb, bcd_err}, 8'h00);
        checkOutput({tag, "_dato"}, dato_out, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b [9];
        logic [7:0] plan [9];
        plan = '{8'h45, 8'h30, 8'h12, 8'h31, 8'h12, 8'h16, 8'h05, 8'h10, 8'h01};
        reset = 1'b0; dato_in = 8'h00; strb = '0; dir = '0; buffer_activo = 1'b0; ready = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #1 checkSnapshot("rst");
        checkOutput("rst_pulses", {6'b0, snap_stb, bcd_err}, 8'h00);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        fullBurst(plan);
        runReady("full", 28, -1, 8'h00);

        buffer_activo = 1'b1; dir = 10'b0000000100;
        #1 checkOutput("addr_min", dato_out, 8'h22);
        dir[0] = 1'b1;
        #1 checkOutput("addr_com", dato_out, 8'hF0);
        buffer_activo = 1'b0;
        #1 checkOutput("addr_off", dato_out, 8'h00);
        for (int k = 0; k < 40; k++) begin
            buffer_activo = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 10; i++) dir[i] = ($urandom_range(0, 4) == 0);
            #1 checkOutput("addr_rand", dato_out, addrModel(buffer_activo, dir));
        end
        buffer_activo = 1'b0; dir = '0;
        @(posedge clk); #1;

        b = plan; b[1] = 8'h5A;
        fullBurst(b);
        runReady("badbcd", 2, -1, 8'h00);

        for (int i = 0; i < 9; i++) if (i != 6) applyStimulus(i, plan[i]);
        runReady("incomplete", 1, -1, 8'h00);
        fullBurst(plan);
        runReady("recover", 1, -1, 8'h00);

        applyStimulus(0, 8'h11);
        applyStimulus(0, 8'h22);
        applyStimulus(0, 8'h33);
        for (int i = 1; i < 9; i++) applyStimulus(i, randBcd());
        runReady("multistrobe", 1, -1, 8'h00);

        strb = 9'h1FF; dato_in = 8'h27;
        @(posedge clk); #1;
        strb = '0;
        for (int i = 0; i < 9; i++) begin m_shadow[i] = 8'h27; m_cap[i] = 1'b1; end
        runReady("simul", 1, -1, 8'h00);

        for (int i = 0; i < 9; i++) b[i] = randBcd();
        fullBurst(b);
        runReady("risestrb", 1, 0, 8'h59);
        for (int i = 1; i < 9; i++) applyStimulus(i, randBcd());
        runReady("carry", 1, -1, 8'h00);

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 9; i++) begin
                if ($urandom_range(0, 19) != 0)
                    applyStimulus(i, ($urandom_range(0, 19) == 0) ? 8'($urandom) : randBcd());
            end
            runReady("rand", $urandom_range(0, 3), -1, 8'h00);
        end

        for (int i = 0; i < 5; i++) applyStimulus(i, plan[i]);
        doReset("midrst");
        for (int i = 5; i < 9; i++) applyStimulus(i, plan[i]);
        runReady("afterrst", 1, -1, 8'h00);

        b = plan; b[1] = 8'h5A;
        for (int k = 0; k < 256; k++) begin
            fullBurst(b);
            runReady("sat", 0, -1, 8'h00);
        end
        checkOutput("sat_final", err_cnt, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
